// File: rtl/idma_obi_legalizer_pkg.sv
// Shared types for the iDMA OBI read/write legalizers.
// The typedefs are sized for the default bus geometry; a legalizer built with
// overridden widths must be paired with a package built to the same geometry.
package idma_obi_legalizer_pkg;

  localparam int unsigned DefDataWidth  = 32;
  localparam int unsigned DefAddrWidth  = 32;
  localparam int unsigned DefTfLenWidth = 32;
  localparam int unsigned DefStrbWidth  = DefDataWidth / 8;
  localparam int unsigned OffsetWidth   = $clog2(DefStrbWidth);

  typedef logic [OffsetWidth-1:0]   offset_t;
  typedef logic [DefAddrWidth-1:0]  addr_t;
  typedef logic [DefTfLenWidth-1:0] len_t;

  // Per-beat read datapath descriptor consumed by the transport layer.
  typedef struct packed {
    offset_t offset;
    offset_t tailer;
    offset_t shift;
  } r_dp_desc_t;

  typedef enum logic {
    LEG_IDLE  = 1'b0,
    LEG_BURST = 1'b1
  } leg_state_e;

endpackage

// File: rtl/idma_stream_fork2.sv
// Two-way valid/ready fork with per-output sent flags.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   valid_i         upstream item present
//   ready_o         upstream item retires (both outputs handshaken or already sent)
//   valid_o[1:0]    per-output valid, dropped once that output has been accepted
//   ready_i[1:0]    per-output ready
module idma_stream_fork2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [1:0] valid_o,
  input  logic [1:0] ready_i
);

  logic [1:0] sent_q, sent_d;
  logic [1:0] hs;
  logic [1:0] done;

  // An output already accepted for the current item stays silent until retire.
  always_comb begin
    valid_o = {2{valid_i}} & ~sent_q;
    hs      = valid_o & ready_i;
    done    = sent_q | hs;
    ready_o = valid_i & (&done);
    sent_d  = ready_o ? 2'b00 : (sent_q | hs);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sent_q <= 2'b00;
    end else begin
      sent_q <= sent_d;
    end
  end

endmodule

// File: rtl/idma_obi_read_legalizer.sv
// Read-side legalizer: splits one 1D transfer into word-aligned single-beat
// OBI read requests plus the matching read datapath descriptor per beat.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   req_src_addr_i/req_dst_addr_i       transfer byte addresses (dst only sets shift)
//   req_length_i, req_valid_i/ready_o   transfer length in bytes and handshake
//   ar_addr_o, ar_valid_o/ready_i       word-aligned read request channel
//   r_dp_offset/tailer/shift_o          read datapath descriptor
//   r_dp_valid_o/ready_i                descriptor handshake
//   busy_o                              a transfer is being split
module idma_obi_read_legalizer
  import idma_obi_legalizer_pkg::*;
#(
  parameter int unsigned DataWidth  = DefDataWidth,
  parameter int unsigned AddrWidth  = DefAddrWidth,
  parameter int unsigned TfLenWidth = DefTfLenWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [AddrWidth-1:0]                req_src_addr_i,
  input  logic [AddrWidth-1:0]                req_dst_addr_i,
  input  logic [TfLenWidth-1:0]               req_length_i,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  output logic [AddrWidth-1:0]                ar_addr_o,
  output logic                                ar_valid_o,
  input  logic                                ar_ready_i,
  output logic [$clog2(DataWidth/8)-1:0]      r_dp_offset_o,
  output logic [$clog2(DataWidth/8)-1:0]      r_dp_tailer_o,
  output logic [$clog2(DataWidth/8)-1:0]      r_dp_shift_o,
  output logic                                r_dp_valid_o,
  input  logic                                r_dp_ready_i,
  output logic                                busy_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffW      = $clog2(StrbWidth);

  leg_state_e             state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [TfLenWidth-1:0]  rem_q, rem_d;
  r_dp_desc_t             desc_q, desc_d;

  logic                   in_burst;
  logic                   beat_done;
  logic [1:0]             fork_valid;
  logic [1:0]             fork_ready;
  logic [TfLenWidth-1:0]  room;
  logic [TfLenWidth-1:0]  beat_bytes;
  logic                   last_beat;

  // Unused top bytes of a beat starting at off with rem bytes left; zero
  // unless this beat is the last one. Comparing before subtracting keeps the
  // arithmetic safe for the maximum length.
  function automatic offset_t tail_of(input logic [TfLenWidth-1:0] rem,
                                      input offset_t               off);
    logic [TfLenWidth-1:0] room_f;
    room_f = TfLenWidth'(StrbWidth) - TfLenWidth'(off);
    return (rem <= room_f) ? OffW'(room_f - rem) : '0;
  endfunction

  // Next-state and datapath update; the tailer is precomputed for the next
  // beat so every descriptor field leaves straight from a register.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    desc_d     = desc_q;
    room       = TfLenWidth'(StrbWidth) - TfLenWidth'(desc_q.offset);
    last_beat  = (rem_q <= room);
    beat_bytes = last_beat ? rem_q : room;

    case (state_q)
      LEG_IDLE: begin
        if (req_valid_i && (req_length_i != '0)) begin
          state_d       = LEG_BURST;
          addr_d        = {req_src_addr_i[AddrWidth-1:OffW], OffW'(0)};
          rem_d         = req_length_i;
          desc_d.offset = req_src_addr_i[OffW-1:0];
          desc_d.shift  = req_src_addr_i[OffW-1:0] - req_dst_addr_i[OffW-1:0];
          desc_d.tailer = tail_of(req_length_i, req_src_addr_i[OffW-1:0]);
        end
      end
      LEG_BURST: begin
        if (beat_done) begin
          rem_d         = rem_q - beat_bytes;
          addr_d        = addr_q + AddrWidth'(StrbWidth);
          desc_d.offset = '0;
          desc_d.tailer = tail_of(rem_q - beat_bytes, '0);
          if (last_beat) begin
            state_d = LEG_IDLE;
          end
        end
      end
      default: begin
        state_d = LEG_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LEG_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      desc_q  <= desc_d;
    end
  end

  assign in_burst   = (state_q == LEG_BURST);
  assign fork_ready = {r_dp_ready_i, ar_ready_i};

  // Read request and descriptor are accepted independently per beat.
  idma_stream_fork2 i_fork (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (in_burst),
    .ready_o (beat_done),
    .valid_o (fork_valid),
    .ready_i (fork_ready)
  );

  assign req_ready_o   = (state_q == LEG_IDLE);
  assign busy_o        = in_burst;
  assign ar_addr_o     = addr_q;
  assign ar_valid_o    = fork_valid[0];
  assign r_dp_valid_o  = fork_valid[1];
  assign r_dp_offset_o = desc_q.offset;
  assign r_dp_tailer_o = desc_q.tailer;
  assign r_dp_shift_o  = desc_q.shift;

endmodule

// File: tb/tb_idma_obi_read_legalizer.sv
// Bench for idma_obi_read_legalizer (DataWidth=32): directed vector table,
// reset and backpressure sequences, and randomized transfers compared against
// a per-transfer beat list computed from byte arithmetic.
module tb_idma_obi_read_legalizer;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] req_src_addr = '0;
  logic [31:0] req_dst_addr = '0;
  logic [31:0] req_length = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready = 1'b1;
  logic [1:0]  r_dp_offset, r_dp_tailer, r_dp_shift;
  logic        r_dp_valid;
  logic        r_dp_ready = 1'b1;
  logic        busy;

  always #5 clk = ~clk;

  idma_obi_read_legalizer dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_src_addr_i (req_src_addr),
    .req_dst_addr_i (req_dst_addr),
    .req_length_i   (req_length),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .ar_addr_o      (ar_addr),
    .ar_valid_o     (ar_valid),
    .ar_ready_i     (ar_ready),
    .r_dp_offset_o  (r_dp_offset),
    .r_dp_tailer_o  (r_dp_tailer),
    .r_dp_shift_o   (r_dp_shift),
    .r_dp_valid_o   (r_dp_valid),
    .r_dp_ready_i   (r_dp_ready),
    .busy_o         (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Ready generation: 0 = both high, 1 = random, 2 = ar low 3 of every 4 cycles.
  int ready_mode = 0;
  int skew_cnt = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: begin
        ar_ready   = 1'($urandom_range(0, 1));
        r_dp_ready = 1'($urandom_range(0, 1));
      end
      2: begin
        skew_cnt   = (skew_cnt + 1) % 4;
        ar_ready   = (skew_cnt == 3);
        r_dp_ready = 1'b1;
      end
      default: begin
        ar_ready   = 1'b1;
        r_dp_ready = 1'b1;
      end
    endcase
  end

  // Handshake monitor, sampled mid-cycle while inputs are stable.
  logic [31:0] ar_seen[$];
  logic [5:0]  rdp_seen[$];
  int          busy_cycles = 0;
  int          rdp_valid_cycles = 0;
  logic        ar_pend = 1'b0, rdp_pend = 1'b0;
  logic [31:0] ar_pend_addr = '0;
  logic [5:0]  rdp_pend_desc = '0;

  always @(negedge clk) begin
    if (rst_ni) begin
      if (ar_pend)
        check("ar_hold", {31'b0, ar_valid, ar_addr}, {31'b0, 1'b1, ar_pend_addr});
      if (rdp_pend)
        check("rdp_hold", {57'b0, r_dp_valid, r_dp_offset, r_dp_tailer, r_dp_shift},
              {57'b0, 1'b1, rdp_pend_desc});
      if (ar_valid && ar_ready) ar_seen.push_back(ar_addr);
      if (r_dp_valid && r_dp_ready) rdp_seen.push_back({r_dp_offset, r_dp_tailer, r_dp_shift});
      if (busy) busy_cycles++;
      if (r_dp_valid) rdp_valid_cycles++;
      ar_pend       = ar_valid && !ar_ready;
      ar_pend_addr  = ar_addr;
      rdp_pend      = r_dp_valid && !r_dp_ready;
      rdp_pend_desc = {r_dp_offset, r_dp_tailer, r_dp_shift};
    end else begin
      ar_pend  = 1'b0;
      rdp_pend = 1'b0;
    end
  end

  function automatic logic [63:0] ar_at(input int k);
    return (k < ar_seen.size()) ? {32'b0, ar_seen[k]} : 64'hDEAD_0000_0000_0000;
  endfunction

  function automatic logic [63:0] rdp_at(input int k);
    return (k < rdp_seen.size()) ? {58'b0, rdp_seen[k]} : 64'hDEAD_0000_0000_0000;
  endfunction

  function automatic longint beats_of(input logic [31:0] src, input logic [31:0] len);
    if (len == 0) return 0;
    return ({32'b0, src} % 4 + {32'b0, len} + 3) / 4;
  endfunction

  // Reference: beat k covers word k of the byte span [src, src+len).
  task automatic expect_beats(input string tag, input logic [31:0] src,
                              input logic [31:0] dst, input logic [31:0] len);
    longint ls, ld, ll, nb, base, e_off, e_tail, e_shift;
    ls = {32'b0, src};
    ld = {32'b0, dst};
    ll = {32'b0, len};
    nb = beats_of(src, len);
    base = ls - ls % 4;
    e_shift = (ls % 4 - ld % 4 + 4) % 4;
    check({tag, " ar_count"}, 64'(ar_seen.size()), 64'(nb));
    check({tag, " rdp_count"}, 64'(rdp_seen.size()), 64'(nb));
    for (int k = 0; k < int'(nb); k++) begin
      e_off  = (k == 0) ? ls % 4 : 0;
      e_tail = (k == int'(nb) - 1) ? (4 - (ls + ll) % 4) % 4 : 0;
      check({tag, " ar_addr"}, ar_at(k), {32'b0, 32'(base + 4 * longint'(k))});
      check({tag, " rdp_desc"}, rdp_at(k),
            {58'b0, 2'(e_off), 2'(e_tail), 2'(e_shift)});
    end
  endtask

  // Issue one transfer and wait until the legalizer is idle again.
  task automatic do_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) check("req_ready_wait", 64'(req_ready), 64'd1);
    ar_seen.delete();
    rdp_seen.delete();
    busy_cycles = 0;
    rdp_valid_cycles = 0;
    req_src_addr = src;
    req_dst_addr = dst;
    req_length   = len;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    if (busy) check("done_timeout", 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [31:0] src, dst, len;
    int          nb;
    logic [31:0] first_addr;
    logic [1:0]  first_off;
    logic [31:0] last_addr;
    logic [1:0]  last_tail;
    logic [1:0]  shift;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h1002, 32'h2000, 32'd9, 3, 32'h1000, 2'd2, 32'h1008, 2'd1, 2'd2};
    vecs[1] = '{32'h1001, 32'h3003, 32'd2, 1, 32'h1000, 2'd1, 32'h1000, 2'd1, 2'd2};
    vecs[2] = '{32'h2000, 32'h0000, 32'd4, 1, 32'h2000, 2'd0, 32'h2000, 2'd0, 2'd0};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0000, 32'd8, 2, 32'hFFFF_FFFC, 2'd0, 32'h0000_0000, 2'd0, 2'd0};
    vecs[4] = '{32'h1003, 32'h1000, 32'd1, 1, 32'h1000, 2'd3, 32'h1000, 2'd0, 2'd3};
    vecs[5] = '{32'h0001, 32'h0002, 32'd3, 1, 32'h0000, 2'd1, 32'h0000, 2'd0, 2'd3};
    vecs[6] = '{32'h0010, 32'h0013, 32'd5, 2, 32'h0010, 2'd0, 32'h0014, 2'd3, 2'd1};

    // Reset state.
    #12;
    check("rst ar_valid", 64'(ar_valid), 64'd0);
    check("rst r_dp_valid", 64'(r_dp_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst req_ready", 64'(req_ready), 64'd1);
    check("rst ar_addr", 64'(ar_addr), 64'd0);
    check("rst desc", {58'b0, r_dp_offset, r_dp_tailer, r_dp_shift}, 64'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Directed vectors with both readies high.
    for (int i = 0; i < 7; i++) begin
      do_xfer(vecs[i].src, vecs[i].dst, vecs[i].len);
      check($sformatf("vec%0d beats", i), 64'(ar_seen.size()), 64'(vecs[i].nb));
      check($sformatf("vec%0d busy_cycles", i), 64'(busy_cycles), 64'(vecs[i].nb));
      check($sformatf("vec%0d first_addr", i), ar_at(0), {32'b0, vecs[i].first_addr});
      check($sformatf("vec%0d last_addr", i), ar_at(vecs[i].nb - 1), {32'b0, vecs[i].last_addr});
      check($sformatf("vec%0d first_desc", i), rdp_at(0),
            {58'b0, vecs[i].first_off, (vecs[i].nb == 1) ? vecs[i].last_tail : 2'd0, vecs[i].shift});
      check($sformatf("vec%0d last_desc", i), rdp_at(vecs[i].nb - 1),
            {58'b0, (vecs[i].nb == 1) ? vecs[i].first_off : 2'd0, vecs[i].last_tail, vecs[i].shift});
      check($sformatf("vec%0d req_ready_after", i), 64'(req_ready), 64'd1);
      expect_beats($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].len);
    end

    // Zero length is consumed silently, then an aligned word follows.
    do_xfer(32'h5002, 32'h0, 32'd0);
    check("zero busy_cycles", 64'(busy_cycles), 64'd0);
    check("zero beats", 64'(ar_seen.size()), 64'd0);
    check("zero rdp_valid", 64'(rdp_valid_cycles), 64'd0);
    check("zero req_ready", 64'(req_ready), 64'd1);
    do_xfer(32'h6000, 32'h0, 32'd4);
    expect_beats("after_zero", 32'h6000, 32'h0, 32'd4);

    // Skewed backpressure on the read request channel.
    ready_mode = 2;
    @(posedge clk); #1;
    do_xfer(32'h1002, 32'h2000, 32'd9);
    check("skew rdp_valid_cycles", 64'(rdp_valid_cycles), 64'd3);
    expect_beats("skew", 32'h1002, 32'h2000, 32'd9);
    ready_mode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset during beat 2 of a 5-beat transfer.
    ar_seen.delete();
    rdp_seen.delete();
    req_src_addr = 32'h4000;
    req_dst_addr = 32'h0;
    req_length   = 32'd20;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst beat2_addr", 64'(ar_addr), 64'h4004);
    rst_ni = 1'b0;
    #1;
    check("midrst ar_valid", 64'(ar_valid), 64'd0);
    check("midrst r_dp_valid", 64'(r_dp_valid), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst req_ready", 64'(req_ready), 64'd1);
    check("midrst ar_addr", 64'(ar_addr), 64'd0);
    #20;
    rst_ni = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst ar_count", 64'(ar_seen.size()), 64'd1);
    check("midrst rdp_count", 64'(rdp_seen.size()), 64'd1);
    check("midrst idle_req_ready", 64'(req_ready), 64'd1);
    check("midrst idle_busy", 64'(busy), 64'd0);

    // Randomized transfers and readies.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] src, dst, len;
      src = $urandom;
      dst = $urandom;
      len = 32'($urandom_range(0, 40));
      if (t < 4) src = 32'hFFFF_FFF0 | (src & 32'h3);
      ready_mode = int'($urandom_range(0, 1));
      do_xfer(src, dst, len);
      expect_beats($sformatf("rand%0d", t), src, dst, len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
